// File: rtl/usb_serial_pkg.sv
// ----------------------------------------------------------------------------
// usb_serial_pkg
//   Shared definitions for the USB CDC serial core's asynchronous-serial
//   front end: 8N1 frame constants, the common TX/RX FSM state encoding and
//   the bit-period calculation used to size the baud counters.
// ----------------------------------------------------------------------------
package usb_serial_pkg;

   localparam int   DATA_BITS   = 8;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

   // Both serial FSMs walk the same four phases of an 8N1 frame.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_t;

   // Clock cycles per serial bit, rounded to nearest.
   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/usb_serial_sync_fifo.sv
// ----------------------------------------------------------------------------
// usb_serial_sync_fifo
//   Single-clock first-word-fall-through FIFO. The head entry is presented on
//   pop_data whenever the FIFO is not empty (zero when empty).
//
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     flush               synchronous clear of pointers and occupancy
//     push, push_data     write request / data
//     pop                 consume head entry (ignored when empty)
//     pop_data            head entry
//     full, empty, count  status; count is $clog2(DEPTH)+1 bits wide
//
//   A push into a full FIFO is accepted only when a pop happens in the same
//   cycle, since that pop frees the slot being written.
// ----------------------------------------------------------------------------
module usb_serial_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;

   logic pop_ok;
   logic push_ok;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CNT_W'(DEPTH));
   assign count   = count_reg;
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   // Head slot is only rewritten on push-into-empty or when full with a
   // simultaneous pop, so pop_data changes only on pop or push-into-empty.
   assign pop_data = empty ? '0 : mem_reg[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_reg[wr_ptr_reg] <= push_data;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/usb_serial_uart_phy.sv
// ----------------------------------------------------------------------------
// usb_serial_uart_phy
//   8N1 asynchronous-serial front end for the USB CDC serial core.
//   TX: pops host bytes from the core's OUT pipe and shifts them out on tx.
//   RX: deserialises frames from rx into a FWFT FIFO feeding the IN pipe.
//
//   Ports:
//     clk, reset                      core clock, synchronous active-high reset
//     uart_out_data/_valid/_get       host byte in, one-cycle pop strobe out
//     uart_in_data/_valid/_ready      RX FIFO head toward host
//     uart_dtr                        host-connected flag
//     tx, rx                          serial pins (rx is asynchronous)
//     rx_frame_err, rx_overrun        one-cycle error pulses
//
//   Build option: define USB_SERIAL_UART_PHY_DTR_GATE_EN to gate TX pops and
//   RX pushes on uart_dtr and flush the RX FIFO when uart_dtr falls. When
//   undefined, uart_dtr is ignored.
//
//   CLKS_PER_BIT must be >= 4; RX_FIFO_DEPTH must be a power of two, 2..256.
// ----------------------------------------------------------------------------
module usb_serial_uart_phy
   import usb_serial_pkg::*;
#(
   parameter int CLK_HZ        = 48000000,
   parameter int BAUD          = 115200,
   parameter int RX_FIFO_DEPTH = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] uart_out_data,
   input  logic       uart_out_valid,
   output logic       uart_out_get,
   output logic [7:0] uart_in_data,
   output logic       uart_in_valid,
   input  logic       uart_in_ready,
   input  logic       uart_dtr,
   output logic       tx,
   input  logic       rx,
   output logic       rx_frame_err,
   output logic       rx_overrun
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

   // ------------------------------------------------------------------
   // DTR gating
   // ------------------------------------------------------------------
   logic gate_open;
   logic fifo_flush;

`ifdef USB_SERIAL_UART_PHY_DTR_GATE_EN
   logic dtr_prev_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         dtr_prev_reg <= 1'b0;
      end else begin
         dtr_prev_reg <= uart_dtr;
      end
   end

   assign gate_open  = uart_dtr;
   assign fifo_flush = dtr_prev_reg & ~uart_dtr;
`else
   logic unused_dtr;

   assign unused_dtr = uart_dtr;
   assign gate_open  = 1'b1;
   assign fifo_flush = 1'b0;
`endif

   // ------------------------------------------------------------------
   // TX FSM
   // ------------------------------------------------------------------
   uart_state_t      tx_state_reg;
   logic [CNT_W-1:0] tx_cnt_reg;
   logic [2:0]       tx_bit_reg;
   logic [7:0]       tx_shift_reg;
   logic             tx_reg;
   logic             get_reg;

   // get_reg and tx_reg are registered: the pop strobe coincides with the
   // first cycle of the start bit, and the byte is latched on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state_reg <= ST_IDLE;
         tx_cnt_reg   <= '0;
         tx_bit_reg   <= '0;
         tx_shift_reg <= '0;
         tx_reg       <= STOP_LEVEL;
         get_reg      <= 1'b0;
      end else begin
         get_reg <= 1'b0;
         case (tx_state_reg)
            ST_IDLE: begin
               if (uart_out_valid && gate_open) begin
                  get_reg      <= 1'b1;
                  tx_shift_reg <= uart_out_data;
                  tx_reg       <= START_LEVEL;
                  tx_cnt_reg   <= CNT_LAST;
                  tx_state_reg <= ST_START;
               end
            end
            ST_START: begin
               if (tx_cnt_reg == '0) begin
                  tx_cnt_reg   <= CNT_LAST;
                  tx_bit_reg   <= '0;
                  tx_reg       <= tx_shift_reg[0];
                  tx_state_reg <= ST_DATA;
               end else begin
                  tx_cnt_reg <= tx_cnt_reg - CNT_W'(1);
               end
            end
            ST_DATA: begin
               if (tx_cnt_reg == '0) begin
                  tx_cnt_reg <= CNT_LAST;
                  if (tx_bit_reg == BIT_LAST) begin
                     tx_reg       <= STOP_LEVEL;
                     tx_state_reg <= ST_STOP;
                  end else begin
                     tx_bit_reg   <= tx_bit_reg + 3'd1;
                     tx_shift_reg <= tx_shift_reg >> 1;
                     tx_reg       <= tx_shift_reg[1];
                  end
               end else begin
                  tx_cnt_reg <= tx_cnt_reg - CNT_W'(1);
               end
            end
            ST_STOP: begin
               if (tx_cnt_reg == '0) begin
                  tx_state_reg <= ST_IDLE;
               end else begin
                  tx_cnt_reg <= tx_cnt_reg - CNT_W'(1);
               end
            end
            default: tx_state_reg <= ST_IDLE;
         endcase
      end
   end

   assign tx           = tx_reg;
   assign uart_out_get = get_reg;

   // ------------------------------------------------------------------
   // RX synchroniser, FSM and FIFO
   // ------------------------------------------------------------------
   logic rx_meta_reg;
   logic rx_s_reg;
   logic rx_prev_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_reg <= 1'b1;
         rx_s_reg    <= 1'b1;
         rx_prev_reg <= 1'b1;
      end else begin
         rx_meta_reg <= rx;
         rx_s_reg    <= rx_meta_reg;
         rx_prev_reg <= rx_s_reg;
      end
   end

   uart_state_t      rx_state_reg;
   logic [CNT_W-1:0] rx_cnt_reg;
   logic [2:0]       rx_bit_reg;
   logic [7:0]       rx_shift_reg;
   logic             frame_err_reg;
   logic             overrun_reg;

   logic                          fifo_push;
   logic                          fifo_full;
   logic                          fifo_empty;
   logic                          fifo_pop_ok;
   logic                          rx_good_stop;
   logic [$clog2(RX_FIFO_DEPTH):0] unused_fifo_count;

   assign rx_good_stop = (rx_state_reg == ST_STOP) && (rx_cnt_reg == '0)
                         && (rx_s_reg == STOP_LEVEL);
   assign fifo_push    = rx_good_stop & gate_open;
   assign fifo_pop_ok  = uart_in_ready & ~fifo_empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state_reg  <= ST_IDLE;
         rx_cnt_reg    <= '0;
         rx_bit_reg    <= '0;
         rx_shift_reg  <= '0;
         frame_err_reg <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         frame_err_reg <= 1'b0;
         overrun_reg   <= 1'b0;
         case (rx_state_reg)
            ST_IDLE: begin
               // Edge rather than level, so a low stop bit that lingers
               // after a framing error is not taken as a new start.
               if (rx_prev_reg && !rx_s_reg) begin
                  rx_cnt_reg   <= CNT_HALF;
                  rx_state_reg <= ST_START;
               end
            end
            ST_START: begin
               if (rx_cnt_reg == '0) begin
                  if (rx_s_reg == START_LEVEL) begin
                     rx_cnt_reg   <= CNT_LAST;
                     rx_bit_reg   <= '0;
                     rx_state_reg <= ST_DATA;
                  end else begin
                     rx_state_reg <= ST_IDLE;   // glitch shorter than half a bit
                  end
               end else begin
                  rx_cnt_reg <= rx_cnt_reg - CNT_W'(1);
               end
            end
            ST_DATA: begin
               if (rx_cnt_reg == '0) begin
                  rx_shift_reg <= {rx_s_reg, rx_shift_reg[7:1]};
                  rx_cnt_reg   <= CNT_LAST;
                  if (rx_bit_reg == BIT_LAST) begin
                     rx_state_reg <= ST_STOP;
                  end else begin
                     rx_bit_reg <= rx_bit_reg + 3'd1;
                  end
               end else begin
                  rx_cnt_reg <= rx_cnt_reg - CNT_W'(1);
               end
            end
            ST_STOP: begin
               // Leave at mid-stop so a slightly fast sender's next start
               // edge is still seen.
               if (rx_cnt_reg == '0) begin
                  rx_state_reg <= ST_IDLE;
                  if (rx_s_reg != STOP_LEVEL) begin
                     frame_err_reg <= 1'b1;
                  end else if (gate_open && fifo_full && !fifo_pop_ok) begin
                     overrun_reg <= 1'b1;
                  end
               end else begin
                  rx_cnt_reg <= rx_cnt_reg - CNT_W'(1);
               end
            end
            default: rx_state_reg <= ST_IDLE;
         endcase
      end
   end

   usb_serial_sync_fifo #(
      .WIDTH (8),
      .DEPTH (RX_FIFO_DEPTH)
   ) u_rx_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (fifo_flush),
      .push      (fifo_push),
      .push_data (rx_shift_reg),
      .pop       (uart_in_ready),
      .pop_data  (uart_in_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (unused_fifo_count)
   );

   assign uart_in_valid = ~fifo_empty;
   assign rx_frame_err  = frame_err_reg;
   assign rx_overrun    = overrun_reg;

endmodule

// File: tb/tb_usb_serial_uart_phy.sv
// ----------------------------------------------------------------------------
// tb_usb_serial_uart_phy
//   Scoreboard bench: stimulus pushes expected TX/RX bytes into queues, and
//   independent monitors decode tx and watch the uart_in handshake, popping
//   and comparing as the DUT produces data. 48 MHz / 3 Mbaud -> 16 clk/bit.
// ----------------------------------------------------------------------------
module tb_usb_serial_uart_phy;

   localparam int CLK_HZ = 48000000;
   localparam int BAUD   = 3000000;
   localparam int CPB    = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] uart_out_data;
   logic       uart_out_valid;
   logic       uart_out_get;
   logic [7:0] uart_in_data;
   logic       uart_in_valid;
   logic       uart_in_ready;
   logic       uart_dtr;
   logic       tx;
   logic       rx;
   logic       rx_frame_err;
   logic       rx_overrun;

   always #5 clk = ~clk;

   usb_serial_uart_phy #(
      .CLK_HZ        (CLK_HZ),
      .BAUD          (BAUD),
      .RX_FIFO_DEPTH (16)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .uart_out_data  (uart_out_data),
      .uart_out_valid (uart_out_valid),
      .uart_out_get   (uart_out_get),
      .uart_in_data   (uart_in_data),
      .uart_in_valid  (uart_in_valid),
      .uart_in_ready  (uart_in_ready),
      .uart_dtr       (uart_dtr),
      .tx             (tx),
      .rx             (rx),
      .rx_frame_err   (rx_frame_err),
      .rx_overrun     (rx_overrun)
   );

   int total = 0;
   int bad   = 0;

   logic [7:0] tx_exp_q[$];
   logic [7:0] rx_exp_q[$];

   int   cyc_cnt    = 0;
   int   get_cnt    = 0;
   int   get_double = 0;
   int   ferr_cnt   = 0;
   int   ovr_cnt    = 0;
   int   t_start    = 0;
   int   t_valid    = 0;
   logic get_prev   = 1'b0;
   logic valid_prev = 1'b0;
   bit   tx_mon_en  = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge.
   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) @(posedge clk);
      #1;
   endtask

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Event counters and RX scoreboard, sampled on the falling edge.
   always @(negedge clk) begin
      if (uart_out_get === 1'b1) begin
         get_cnt++;
         if (get_prev === 1'b1) get_double++;
      end
      get_prev = uart_out_get;
      if (rx_frame_err === 1'b1) ferr_cnt++;
      if (rx_overrun === 1'b1) ovr_cnt++;
      if (uart_in_valid === 1'b1 && valid_prev !== 1'b1) t_valid = cyc_cnt;
      valid_prev = uart_in_valid;
      if (uart_in_valid === 1'b1 && uart_in_ready === 1'b1 && reset === 1'b0) begin
         if (rx_exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rx_unexpected: got 0x%0h expected none", uart_in_data);
         end else begin
            check("rx_byte", uart_in_data, rx_exp_q.pop_front());
         end
      end
   end

   // TX decoder: measures start length, samples bits mid-period, checks stop
   // and that the line is idle right after the 160-cycle frame.
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (tx_mon_en && tx === 1'b0) begin
            for (int i = 0; i < 15; i++) @(negedge clk);
            check("tx_start_len", tx, 0);
            for (int i = 0; i < 8; i++) @(negedge clk);
            b[0] = tx;
            for (int k = 1; k < 8; k++) begin
               for (int i = 0; i < 16; i++) @(negedge clk);
               b[k] = tx;
            end
            for (int i = 0; i < 16; i++) @(negedge clk);
            check("tx_stop", tx, 1);
            for (int i = 0; i < 9; i++) @(negedge clk);
            check("tx_idle_after", tx, 1);
            if (tx_exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL tx_unexpected: got 0x%0h expected none", b);
            end else begin
               check("tx_byte", b, tx_exp_q.pop_front());
            end
            $display("tx frame decoded 0x%0h", b);
         end
      end
   end

   task automatic wait_get(input int budget);
      int n = 0;
      while (uart_out_get !== 1'b1 && n < budget) begin
         cyc(1);
         n++;
      end
      check("get_seen", uart_out_get, 1);
   endtask

   task automatic wait_tx_done(input int budget);
      int n = 0;
      while (tx_exp_q.size() != 0 && n < budget) begin
         cyc(1);
         n++;
      end
      check("tx_queue_empty", tx_exp_q.size(), 0);
   endtask

   task automatic wait_rx_drained(input int budget);
      int n = 0;
      while (rx_exp_q.size() != 0 && n < budget) begin
         cyc(1);
         n++;
      end
      check("rx_queue_empty", rx_exp_q.size(), 0);
   endtask

   task automatic send_rx(input logic [7:0] d, input logic stop);
      t_start = cyc_cnt;
      rx = 1'b0;
      cyc(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         cyc(CPB);
      end
      rx = stop;
      cyc(CPB);
      rx = 1'b1;
      cyc(2);
      $display("rx frame sent 0x%0h stop=%0d", d, stop);
   endtask

   initial begin
      reset          = 1'b1;
      rx             = 1'b1;
      uart_out_valid = 1'b0;
      uart_out_data  = 8'h00;
      uart_in_ready  = 1'b0;
      uart_dtr       = 1'b1;
      cyc(3);
      check("rst_tx", tx, 1);
      check("rst_get", uart_out_get, 0);
      check("rst_in_valid", uart_in_valid, 0);
      check("rst_in_data", uart_in_data, 0);
      check("rst_frame_err", rx_frame_err, 0);
      check("rst_overrun", rx_overrun, 0);
      reset = 1'b0;
      cyc(2);

      // TX 0xA5
      tx_exp_q.push_back(8'hA5);
      uart_out_data  = 8'hA5;
      uart_out_valid = 1'b1;
      wait_get(20);
      uart_out_valid = 1'b0;
      wait_tx_done(300);
      check("tx_get_count", get_cnt, 1);

      // RX 0x3C with latency and hold/pop handshake
      rx_exp_q.push_back(8'h3C);
      t_valid = 0;
      send_rx(8'h3C, 1'b1);
      check("rx_latency_window", ((t_valid - t_start) >= 153) && ((t_valid - t_start) <= 157), 1);
      cyc(10);
      check("rx_valid_held", uart_in_valid, 1);
      check("rx_head_data", uart_in_data, 8'h3C);
      uart_in_ready = 1'b1;
      cyc(1);
      uart_in_ready = 1'b0;
      cyc(1);
      check("rx_valid_after_pop", uart_in_valid, 0);
      check("rx_popped", rx_exp_q.size(), 0);

      // Overrun: 17 bytes into a 16-entry FIFO
      for (int i = 0; i < 17; i++) begin
         if (i < 16) rx_exp_q.push_back(8'(i));
         send_rx(8'(i), 1'b1);
      end
      check("ovr_pulses", ovr_cnt, 1);
      check("ovr_valid", uart_in_valid, 1);
      check("ovr_head", uart_in_data, 8'h00);
      uart_in_ready = 1'b1;
      wait_rx_drained(100);
      uart_in_ready = 1'b0;
      cyc(2);
      check("ovr_drained_valid", uart_in_valid, 0);

      // Frame error, then a short glitch, then a good byte
      send_rx(8'h55, 1'b0);
      check("ferr_pulses", ferr_cnt, 1);
      check("ferr_fifo_empty", uart_in_valid, 0);
      rx = 1'b0;
      cyc(4);
      rx = 1'b1;
      cyc(200);
      check("glitch_no_byte", uart_in_valid, 0);
      check("glitch_no_ferr", ferr_cnt, 1);
      check("glitch_no_ovr", ovr_cnt, 1);
      rx_exp_q.push_back(8'hC3);
      uart_in_ready = 1'b1;
      send_rx(8'hC3, 1'b1);
      wait_rx_drained(20);
      uart_in_ready = 1'b0;

      // Reset during bit 3 of 0xFF
      tx_mon_en      = 1'b0;
      uart_out_data  = 8'hFF;
      uart_out_valid = 1'b1;
      wait_get(20);
      uart_out_valid = 1'b0;
      cyc(CPB + 3 * CPB + 8);
      uart_out_data  = 8'h81;
      uart_out_valid = 1'b1;
      reset          = 1'b1;
      cyc(1);
      check("rst_mid_tx", tx, 1);
      check("rst_mid_get", uart_out_get, 0);
      cyc(2);
      check("rst_hold_get", uart_out_get, 0);
      check("rst_hold_tx", tx, 1);
      tx_mon_en = 1'b1;
      tx_exp_q.push_back(8'h81);
      reset = 1'b0;
      wait_get(10);
      uart_out_valid = 1'b0;
      wait_tx_done(300);
      check("get_total", get_cnt, 3);
      check("get_never_double", get_double, 0);

`ifdef USB_SERIAL_UART_PHY_DTR_GATE_EN
      begin
         int   g0;
         logic low_seen;
         int   n;
         g0             = get_cnt;
         low_seen       = 1'b0;
         uart_dtr       = 1'b0;
         uart_out_data  = 8'h5A;
         uart_out_valid = 1'b1;
         for (int i = 0; i < 500; i++) begin
            cyc(1);
            if (tx !== 1'b1) low_seen = 1'b1;
         end
         check("dtr_no_get", get_cnt, g0);
         check("dtr_tx_idle", low_seen, 0);
         tx_exp_q.push_back(8'h5A);
         uart_dtr = 1'b1;
         n = 0;
         cyc(1);
         while (uart_out_get !== 1'b1 && n < 1) begin
            cyc(1);
            n++;
         end
         check("dtr_get_prompt", uart_out_get, 1);
         uart_out_valid = 1'b0;
         wait_tx_done(300);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
